// File: rtl/axicb_wr_arbiter_if.sv
// AW/W handshake and select bundle between the masters, the slave port and the write arbiter.
// The arbiter uses the slave modport; the master modport is the view from the other side.
interface axicb_wr_arbiter_if #(
  parameter int MST_NB = 4
);
  logic [MST_NB-1:0] m_awvalid;
  logic [MST_NB-1:0] m_awready;
  logic [MST_NB-1:0] m_wvalid;
  logic [MST_NB-1:0] m_wlast;
  logic [MST_NB-1:0] m_wready;
  logic              s_awvalid;
  logic              s_awready;
  logic              s_wvalid;
  logic              s_wlast;
  logic              s_wready;
  logic [MST_NB-1:0] aw_sel;
  logic [MST_NB-1:0] w_sel;

  modport slave (
    input  m_awvalid, m_wvalid, m_wlast, s_awready, s_wready,
    output m_awready, m_wready, s_awvalid, s_wvalid, s_wlast, aw_sel, w_sel
  );

  modport master (
    output m_awvalid, m_wvalid, m_wlast, s_awready, s_wready,
    input  m_awready, m_wready, s_awvalid, s_wvalid, s_wlast, aw_sel, w_sel
  );
endinterface

// File: rtl/axicb_wr_arbiter.sv
// Round-robin AW arbiter with an AW-order FIFO that steers W bursts; AW valid 1 cycle after request.
// Grant holds until s_awready; a full FIFO blocks new grants; W beats stall (wready=0) until their AW is queued.
module axicb_wr_arbiter #(
  parameter int MST_NB      = 4,
  parameter int OSTDREQ_NUM = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              srst,
  axicb_wr_arbiter_if.slave bus
);

  localparam int IW = $clog2(MST_NB);
  localparam int PW = $clog2(OSTDREQ_NUM);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nxt;
  logic [MST_NB-1:0] aw_sel_q, aw_sel_nxt;
  logic [MST_NB-1:0] rr_mask, masked, pick, win_oh, above;
  logic [IW-1:0]     aw_idx, head;
  logic [IW-1:0]     fifo_mem [OSTDREQ_NUM];
  logic [PW:0]       wr_ptr, rd_ptr, count;
  logic              full, empty, aw_hs, w_pop;
  logic              awvalid_o, wvalid_o, wlast_o;
  logic [MST_NB-1:0] w_sel_o, m_wready_o;

  // Prefer requesters above the last winner; fall back to the lowest requester.
  always_comb begin
    masked = rr_mask & bus.m_awvalid;
    pick   = (|masked) ? masked : bus.m_awvalid;
    win_oh = pick & (~pick + MST_NB'(1));
  end

  always_comb begin
    aw_idx = '0;
    for (int i = 0; i < MST_NB; i++) begin
      if (aw_sel_q[i]) aw_idx = IW'(i);
    end
  end

  // Bits strictly above the granted master; empty when the top master won.
  assign above = ~(aw_sel_q | (aw_sel_q - MST_NB'(1)));

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (PW+1)'(OSTDREQ_NUM));
  assign empty = (count == '0);
  assign head  = fifo_mem[rd_ptr[PW-1:0]];

  assign awvalid_o     = (state == GRANT) && (|(aw_sel_q & bus.m_awvalid));
  assign aw_hs         = awvalid_o && bus.s_awready;
  assign bus.s_awvalid = awvalid_o;
  assign bus.m_awready = aw_sel_q & {MST_NB{bus.s_awready}};
  assign bus.aw_sel    = aw_sel_q;

  always_comb begin
    w_sel_o    = '0;
    m_wready_o = '0;
    wvalid_o   = 1'b0;
    wlast_o    = 1'b0;
    if (!empty) begin
      w_sel_o[head]    = 1'b1;
      wvalid_o         = bus.m_wvalid[head];
      wlast_o          = bus.m_wlast[head];
      m_wready_o[head] = bus.s_wready;
    end
  end

  assign w_pop        = wvalid_o && bus.s_wready && wlast_o;
  assign bus.w_sel    = w_sel_o;
  assign bus.m_wready = m_wready_o;
  assign bus.s_wvalid = wvalid_o;
  assign bus.s_wlast  = wlast_o;

  always_comb begin
    state_nxt  = state;
    aw_sel_nxt = aw_sel_q;
    case (state)
      IDLE: begin
        if ((|bus.m_awvalid) && !full) begin
          state_nxt  = GRANT;
          aw_sel_nxt = win_oh;
        end
      end
      GRANT: begin
        if (aw_hs) begin
          state_nxt  = IDLE;
          aw_sel_nxt = '0;
        end
      end
      default: begin
        state_nxt  = IDLE;
        aw_sel_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      aw_sel_q <= '0;
    end else if (srst) begin
      state    <= IDLE;
      aw_sel_q <= '0;
    end else begin
      state    <= state_nxt;
      aw_sel_q <= aw_sel_nxt;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_mask <= '1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else if (srst) begin
      rr_mask <= '1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      if (aw_hs) begin
        rr_mask <= (|above) ? above : '1;
        wr_ptr  <= wr_ptr + 1'b1;
      end
      if (w_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge aclk) begin
    if (aw_hs) fifo_mem[wr_ptr[PW-1:0]] <= aw_idx;
  end

endmodule

// File: tb/tb_axicb_wr_arbiter.sv
// Directed bench for axicb_wr_arbiter: expected AW grants and W burst order are queued at stimulus time
// and compared when the DUT shows the matching handshake.
module tb_axicb_wr_arbiter;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  logic srst    = 1'b0;

  always #5 aclk = ~aclk;

  axicb_wr_arbiter_if #(.MST_NB(4)) bus ();

  axicb_wr_arbiter #(.MST_NB(4), .OSTDREQ_NUM(4)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int awq[$];
  int wq[$];
  int beats[4];
  bit w_track = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int oh2idx(input logic [3:0] oh);
    int r = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // One clock; tracks W beats (and drives per-master wlast) when w_track is set. Ends 3 time units after the edge.
  task automatic step();
    logic hs;
    logic last;
    int   idx;
    hs   = w_track && (bus.s_wvalid === 1'b1) && (bus.s_wready === 1'b1);
    idx  = oh2idx(bus.w_sel);
    last = bus.s_wlast;
    if (hs) begin
      chk("w_pending", 32'(wq.size() > 0), 32'd1);
      if (wq.size() > 0) chk("w_order", 32'(bus.w_sel), 32'd1 << wq[0]);
      if (idx == 2) chk("m_wready0_blocked", 32'(bus.m_wready[0]), 32'd0);
    end
    @(posedge aclk);
    #2;
    if (hs) begin
      if (last) begin
        beats[idx] = 0;
        if (wq.size() > 0) void'(wq.pop_front());
      end else begin
        beats[idx]++;
      end
      bus.m_wlast[idx] = (beats[idx] == 2);
    end
    #1;
    if (hs && last && wq.size() > 0) chk("w_next_head", 32'(bus.w_sel), 32'd1 << wq[0]);
  endtask

  // Steps until an AW handshake is pending (without consuming its edge) and checks it against the queue.
  task automatic aw_wait(input int lat);
    int n = 0;
    int exp = 0;
    do begin
      step();
      n++;
    end while (!(bus.s_awvalid === 1'b1 && bus.s_awready === 1'b1) && n < 20);
    chk("aw_expected", 32'(awq.size() > 0), 32'd1);
    if (awq.size() > 0) exp = awq.pop_front();
    chk("aw_hs", 32'(bus.s_awvalid && bus.s_awready), 32'd1);
    chk("aw_sel", 32'(bus.aw_sel), 32'd1 << exp);
    chk("m_awready", 32'(bus.m_awready), 32'd1 << exp);
    chk("aw_latency", 32'(n), 32'(lat));
  endtask

  initial begin
    bus.m_awvalid = '0;
    bus.m_wvalid  = '0;
    bus.m_wlast   = '0;
    bus.s_awready = 1'b0;
    bus.s_wready  = 1'b0;
    for (int i = 0; i < 4; i++) beats[i] = 0;

    // Reset state
    repeat (3) @(posedge aclk);
    #3;
    chk("rst_aw_sel", 32'(bus.aw_sel), 32'd0);
    chk("rst_w_sel", 32'(bus.w_sel), 32'd0);
    chk("rst_s_awvalid", 32'(bus.s_awvalid), 32'd0);
    chk("rst_s_wvalid", 32'(bus.s_wvalid), 32'd0);
    chk("rst_m_awready", 32'(bus.m_awready), 32'd0);
    chk("rst_m_wready", 32'(bus.m_wready), 32'd0);
    chk("rst_mask", 32'(dut.rr_mask), 32'hf);
    aresetn = 1'b1;

    // All four requesting: strict rotation, single-beat bursts drain immediately
    bus.s_wready  = 1'b1;
    bus.m_wvalid  = 4'b1111;
    bus.m_wlast   = 4'b1111;
    bus.s_awready = 1'b1;
    bus.m_awvalid = 4'b1111;
    awq.push_back(0); awq.push_back(1); awq.push_back(2); awq.push_back(3); awq.push_back(0);
    for (int k = 0; k < 4; k++) begin
      aw_wait(1);
      step();
      chk("rot_idle_after_hs", 32'(bus.s_awvalid), 32'd0);
    end
    chk("mask_after_3", 32'(dut.rr_mask), 32'hf);
    aw_wait(1);
    step();
    bus.m_awvalid = '0;
    repeat (3) step();
    chk("rot_drained", 32'(bus.w_sel), 32'd0);

    // 1101 requesting after a sync reset: master 1 skipped
    srst = 1'b1;
    step();
    srst = 1'b0;
    chk("srst_mask", 32'(dut.rr_mask), 32'hf);
    bus.m_awvalid = 4'b1101;
    awq.push_back(0); awq.push_back(2); awq.push_back(3); awq.push_back(0);
    aw_wait(1); step();
    aw_wait(1); step();
    chk("mask_after_2", 32'(dut.rr_mask), 32'h8);
    aw_wait(1); step();
    aw_wait(1); step();
    bus.m_awvalid = '0;
    repeat (3) step();

    // FIFO full blocks the fifth AW until one burst completes
    bus.s_wready  = 1'b0;
    bus.m_wvalid  = '0;
    bus.m_wlast   = '0;
    bus.m_awvalid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      awq.push_back(1);
      aw_wait(1);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      step();
      chk("full_m_awready", 32'(bus.m_awready), 32'd0);
      chk("full_aw_sel", 32'(bus.aw_sel), 32'd0);
    end
    bus.m_wvalid = 4'b0010;
    bus.m_wlast  = 4'b0010;
    bus.s_wready = 1'b1;
    #1;
    chk("full_w_sel", 32'(bus.w_sel), 32'h2);
    chk("full_m_wready", 32'(bus.m_wready), 32'h2);
    awq.push_back(1);
    aw_wait(2);
    step();
    bus.m_awvalid = '0;
    repeat (8) step();
    chk("full_drained", 32'(bus.w_sel), 32'd0);
    bus.m_wvalid = '0;
    bus.m_wlast  = '0;

    // AW order 2 then 0, both with concurrent 3-beat bursts
    w_track      = 1'b1;
    bus.m_wvalid = 4'b0101;
    bus.m_awvalid = 4'b0100;
    awq.push_back(2); wq.push_back(2);
    aw_wait(1);
    step();
    chk("w_first_sel", 32'(bus.w_sel), 32'h4);
    bus.m_awvalid = 4'b0001;
    awq.push_back(0); wq.push_back(0);
    aw_wait(1);
    step();
    bus.m_awvalid = '0;
    for (int n = 0; n < 20 && wq.size() > 0; n++) step();
    chk("order_drained", 32'(wq.size()), 32'd0);
    bus.m_wvalid = '0;

    // W before AW: stalled until the cycle after the AW handshake
    bus.m_wvalid = 4'b0010;
    step();
    step();
    chk("early_s_wvalid", 32'(bus.s_wvalid), 32'd0);
    chk("early_m_wready", 32'(bus.m_wready), 32'd0);
    bus.m_awvalid = 4'b0010;
    awq.push_back(1); wq.push_back(1);
    aw_wait(1);
    chk("early_hs_s_wvalid", 32'(bus.s_wvalid), 32'd0);
    chk("early_hs_m_wready", 32'(bus.m_wready), 32'd0);
    step();
    bus.m_awvalid = '0;
    chk("after_hs_s_wvalid", 32'(bus.s_wvalid), 32'd1);
    chk("after_hs_m_wready", 32'(bus.m_wready), 32'h2);
    for (int n = 0; n < 20 && wq.size() > 0; n++) step();
    chk("early_drained", 32'(wq.size()), 32'd0);
    bus.m_wvalid = '0;
    bus.m_wlast  = '0;
    w_track      = 1'b0;

    // srst while in GRANT with two queued entries
    bus.s_wready  = 1'b0;
    bus.m_awvalid = 4'b1100;
    awq.push_back(2); awq.push_back(3);
    aw_wait(1); step();
    aw_wait(1); step();
    bus.s_awready = 1'b0;
    step();
    chk("pre_srst_aw_sel", 32'(bus.aw_sel), 32'h4);
    chk("pre_srst_w_sel", 32'(bus.w_sel), 32'h4);
    srst = 1'b1;
    step();
    srst = 1'b0;
    chk("srst_aw_sel", 32'(bus.aw_sel), 32'd0);
    chk("srst_w_sel", 32'(bus.w_sel), 32'd0);
    chk("srst_s_awvalid", 32'(bus.s_awvalid), 32'd0);
    chk("srst_mask_grant", 32'(dut.rr_mask), 32'hf);
    bus.m_awvalid = 4'b1110;
    bus.s_awready = 1'b1;
    awq.push_back(1);
    aw_wait(1);
    step();
    bus.m_awvalid = '0;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
